// File: rtl/fnd_pkg.sv
// Shared constants, conversion-state type and seven-segment decoding for
// the APB seven-segment scan controller.
package fnd_pkg;

  localparam logic [1:0] ADDR_FCR = 2'd0;
  localparam logic [1:0] ADDR_FDR = 2'd1;
  localparam logic [1:0] ADDR_FPR = 2'd2;
  localparam logic [1:0] ADDR_FSR = 2'd3;

  localparam int FCR_EN    = 0;
  localparam int FCR_HEX   = 1;
  localparam int FCR_LZB   = 2;
  localparam int FCR_BLINK = 3;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_LOAD  = 2'd2
  } conv_state_e;

  // Segment patterns are {g..a}, active-low.
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// Iterative double-dabble: one add-3/shift step per cycle for DATA_W cycles
// after i_start; o_done marks the cycle whose edge performs the last step.
module fnd_bin2bcd #(
  parameter int DATA_W     = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [DATA_W-1:0]       i_value,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*NUM_DIGITS-1:0] o_bcd
);
  localparam int NIB_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_bin;
  logic [NIB_W-1:0]  r_bcd;
  logic [CNT_W-1:0]  r_cnt;
  logic [NIB_W-1:0]  w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_value;
      r_bcd <= '0;
      r_cnt <= CNT_W'(DATA_W);
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj[NIB_W-2:0], r_bin[DATA_W-1]};
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0);
  assign o_done = (r_cnt == CNT_W'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/apb_fnd_scan_ctrl.sv
// APB seven-segment controller: register file, conversion sequencing,
// scan divider/blink and registered digit/segment drive.
module apb_fnd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14,
  parameter int TICK_DIV   = 100_000,
  parameter int BLINK_DIV  = 250
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [3:0]            PADDR,
  input  logic [31:0]           PWDATA,
  input  logic                  PWRITE,
  input  logic                  PENABLE,
  input  logic                  PSEL,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic [NUM_DIGITS-1:0] fnd_comm,
  output logic [7:0]            fnd_font
);
  import fnd_pkg::*;

  localparam int NIB_W  = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [63:0] DEC_MAX = pow10(NUM_DIGITS) - 64'd1;

  logic [3:0]            r_fcr;
  logic [DATA_W-1:0]     r_fdr;
  logic [NUM_DIGITS-1:0] r_fpr;
  logic [31:0]           r_prdata;
  logic                  r_pready;
  logic                  r_trig;
  conv_state_e           r_state;
  logic [NIB_W-1:0]      r_buf;
  logic                  r_ovf;
  logic [DIV_W-1:0]      r_div;
  logic [IDX_W-1:0]      r_idx;
  logic [BCNT_W-1:0]     r_bcnt;
  logic                  r_blink_ph;
  logic [NUM_DIGITS-1:0] r_comm;
  logic [7:0]            r_font;

  logic                  w_access, w_wr, w_rd, w_busy, w_tick, w_lit, w_lz, w_ovf;
  logic                  w_eng_start, w_eng_busy, w_eng_done, w_unused_bits;
  logic [1:0]            w_sel;
  logic [31:0]           w_rdata;
  logic [63:0]           w_fdr64;
  logic [NIB_W-1:0]      w_hex_val, w_eng_bcd, w_upper;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;

  // Handshake: a transfer commits on the edge where PSEL & PENABLE are high
  // and PREADY is still low; PREADY is high for exactly the following cycle.
  assign w_access      = PSEL & PENABLE & ~r_pready;
  assign w_wr          = w_access & PWRITE;
  assign w_rd          = w_access & ~PWRITE;
  assign w_sel         = PADDR[3:2];
  assign w_busy        = (r_state != CONV_IDLE);
  assign w_unused_bits = ^{PADDR[1:0], PWDATA};

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      ADDR_FCR: w_rdata[3:0]            = r_fcr;
      ADDR_FDR: w_rdata[DATA_W-1:0]     = r_fdr;
      ADDR_FPR: w_rdata[NUM_DIGITS-1:0] = r_fpr;
      default:  w_rdata[1:0]            = {r_ovf, w_busy};
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_fcr    <= '0;
      r_fdr    <= '0;
      r_fpr    <= '0;
      r_prdata <= '0;
      r_pready <= 1'b0;
      r_trig   <= 1'b0;
    end else begin
      r_pready <= w_access;
      r_trig   <= w_wr && ((w_sel == ADDR_FDR) ||
                  (w_sel == ADDR_FCR && PWDATA[FCR_HEX] != r_fcr[FCR_HEX]));
      if (w_rd) r_prdata <= w_rdata;
      if (w_wr) begin
        case (w_sel)
          ADDR_FCR: r_fcr <= PWDATA[3:0];
          ADDR_FDR: r_fdr <= PWDATA[DATA_W-1:0];
          ADDR_FPR: r_fpr <= PWDATA[NUM_DIGITS-1:0];
          default: ;
        endcase
      end
    end
  end

  assign w_eng_start = r_trig & ~r_fcr[FCR_HEX];

  fnd_bin2bcd #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .i_clk   (PCLK),
    .i_rst   (PRESET),
    .i_start (w_eng_start),
    .i_value (r_fdr),
    .o_busy  (w_eng_busy),
    .o_done  (w_eng_done),
    .o_bcd   (w_eng_bcd)
  );

  assign w_fdr64   = 64'(r_fdr);
  assign w_hex_val = w_fdr64[NIB_W-1:0];
  assign w_ovf     = r_fcr[FCR_HEX] ? ((w_fdr64 >> NIB_W) != 64'd0) : (w_fdr64 > DEC_MAX);

  // A pending trigger always wins, so a restart discards a half-done conversion.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= CONV_IDLE;
      r_buf   <= '0;
      r_ovf   <= 1'b0;
    end else if (r_trig) begin
      r_state <= r_fcr[FCR_HEX] ? CONV_LOAD : CONV_SHIFT;
    end else begin
      case (r_state)
        CONV_SHIFT: if (w_eng_done || !w_eng_busy) r_state <= CONV_LOAD;
        CONV_LOAD: begin
          r_buf   <= r_fcr[FCR_HEX] ? w_hex_val : w_eng_bcd;
          r_ovf   <= w_ovf;
          r_state <= CONV_IDLE;
        end
        default: r_state <= CONV_IDLE;
      endcase
    end
  end

  assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_div      <= '0;
      r_idx      <= '0;
      r_bcnt     <= '0;
      r_blink_ph <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        if (r_bcnt == BCNT_W'(BLINK_DIV - 1)) begin
          r_bcnt     <= '0;
          r_blink_ph <= ~r_blink_ph;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end
    end
  end

  // Blink phase 0 is the lit half.
  assign w_lit   = r_fcr[FCR_EN] & (~r_fcr[FCR_BLINK] | ~r_blink_ph);
  assign w_nib   = r_buf[4*r_idx +: 4];
  assign w_upper = r_buf >> (4 * r_idx);
  assign w_lz    = r_fcr[FCR_LZB] && (r_idx != '0) && (w_upper == '0);
  assign w_seg   = r_ovf ? SEG_DASH : (w_lz ? SEG_BLANK : seg7(w_nib));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_comm <= '1;
      r_font <= 8'hFF;
    end else begin
      r_comm <= w_lit ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      r_font <= w_lit ? {~r_fpr[r_idx], w_seg} : 8'hFF;
    end
  end

  assign PRDATA   = r_prdata;
  assign PREADY   = r_pready;
  assign fnd_comm = r_comm;
  assign fnd_font = r_font;

endmodule

// File: tb/tb_apb_fnd_scan_ctrl.sv
// Directed bench for apb_fnd_scan_ctrl: register access, decimal/hex display,
// blanking, overflow, conversion restart, blink and reset abort.
module tb_apb_fnd_scan_ctrl;

  localparam int NUM_DIGITS = 4;
  localparam int DATA_W     = 20;
  localparam int TICK_DIV   = 4;
  localparam int BLINK_DIV  = 2;

  localparam logic [3:0] A_FCR = 4'h0;
  localparam logic [3:0] A_FDR = 4'h4;
  localparam logic [3:0] A_FPR = 4'h8;
  localparam logic [3:0] A_FSR = 4'hC;

  logic                  clk;
  logic                  PRESET;
  logic [3:0]            PADDR;
  logic [31:0]           PWDATA;
  logic                  PWRITE, PENABLE, PSEL;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic [NUM_DIGITS-1:0] fnd_comm;
  logic [7:0]            fnd_font;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  logic watch_nine = 1'b0;
  int   seen_nine  = 0;

  apb_fnd_scan_ctrl #(
    .NUM_DIGITS (NUM_DIGITS),
    .DATA_W     (DATA_W),
    .TICK_DIV   (TICK_DIV),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .PCLK     (clk),
    .PRESET   (PRESET),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .fnd_comm (fnd_comm),
    .fnd_font (fnd_font)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (watch_nine && fnd_font == 8'h90) seen_nine++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    data = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Scoreboard: expected read data goes through exp_q
  task automatic rd_expect(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    logic [31:0] e;
    exp_q.push_back(exp);
    apb_read(addr, d);
    e = exp_q.pop_front();
    check(tag, d, e);
  endtask

  task automatic wait_digit(input int d, input int budget, output logic [7:0] font, output int cycles);
    logic [3:0] m;
    logic found;
    m = 4'b0001 << d;
    found = 1'b0;
    cycles = 0;
    font = 8'h00;
    while (!found && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (fnd_comm == ~m) begin
        found = 1'b1;
        font = fnd_font;
      end
    end
    check($sformatf("digit%0d_seen", d), {31'd0, found}, 32'd1);
  endtask

  task automatic show(input int d, input logic [7:0] exp, input string tag);
    logic [7:0] f;
    int c;
    wait_digit(d, 64, f, c);
    check(tag, {24'd0, f}, {24'd0, exp});
  endtask

  initial begin
    logic [7:0] f;
    int c;
    int run;
    logic prev_lit, found, done;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 4'h0; PWDATA = 32'h0;
    idle(3);
    PRESET = 1'b0;

    // Reset state and handshake timing
    check("rst_comm", {28'd0, fnd_comm}, 32'hF);
    check("rst_font", {24'd0, fnd_font}, 32'hFF);
    check("rst_pready", {31'd0, PREADY}, 32'd0);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = A_FCR; PENABLE = 1'b0;
    @(posedge clk); #1;
    check("pready_setup", {31'd0, PREADY}, 32'd0);
    PENABLE = 1'b1;
    @(posedge clk); #1;
    check("pready_access", {31'd0, PREADY}, 32'd1);
    check("rst_fcr", PRDATA, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1;
    check("pready_drop", {31'd0, PREADY}, 32'd0);
    rd_expect(A_FDR, 32'h0, "rst_fdr");
    rd_expect(A_FPR, 32'h0, "rst_fpr");
    rd_expect(A_FSR, 32'h0, "rst_fsr");
    check("rst_comm_after", {28'd0, fnd_comm}, 32'hF);
    check("rst_font_after", {24'd0, fnd_font}, 32'hFF);

    // Decimal 1234 with scan order and tick period
    apb_write(A_FCR, 32'h1);
    apb_write(A_FDR, 32'd1234);
    rd_expect(A_FSR, 32'h1, "t2_busy");
    idle(30);
    rd_expect(A_FSR, 32'h0, "t2_idle");
    rd_expect(A_FDR, 32'd1234, "t2_fdr");
    wait_digit(3, 64, f, c);
    wait_digit(0, 64, f, c);
    check("t2_dig0", {24'd0, f}, 32'h99);
    wait_digit(1, 64, f, c);
    check("t2_dig1", {24'd0, f}, 32'hB0);
    check("t2_tick_period", c, 32'd4);
    show(2, 8'hA4, "t2_dig2");
    show(3, 8'hF9, "t2_dig3");

    // Implemented-bit masking, FSR read-only, decimal overflow from width limit
    apb_write(A_FPR, 32'hFFFF_FFFF);
    rd_expect(A_FPR, 32'hF, "mask_fpr");
    apb_write(A_FPR, 32'h0);
    apb_write(A_FCR, 32'hFFFF_FFF1);
    rd_expect(A_FCR, 32'h1, "mask_fcr");
    apb_write(A_FSR, 32'h3);
    rd_expect(A_FSR, 32'h0, "fsr_ro");
    apb_write(A_FDR, 32'hFFFF_FFFF);
    rd_expect(A_FDR, 32'h000F_FFFF, "mask_fdr");
    idle(30);
    rd_expect(A_FSR, 32'h2, "dec_ovf_big");
    show(2, 8'hBF, "dec_ovf_dash");

    // Leading-zero blanking, decimal overflow boundary
    apb_write(A_FCR, 32'h5);
    apb_write(A_FDR, 32'd7);
    idle(30);
    rd_expect(A_FSR, 32'h0, "t3_no_ovf");
    show(0, 8'hF8, "t3_dig0");
    show(1, 8'hFF, "t3_dig1_blank");
    show(3, 8'hFF, "t3_dig3_blank");
    apb_write(A_FDR, 32'd9999);
    idle(30);
    rd_expect(A_FSR, 32'h0, "dec_9999_ok");
    apb_write(A_FDR, 32'd10000);
    idle(30);
    rd_expect(A_FSR, 32'h2, "dec_10000_ovf");

    // Hex mode, hex overflow boundary, hex blanking
    apb_write(A_FCR, 32'h3);
    apb_write(A_FDR, 32'hBEEF);
    idle(5);
    rd_expect(A_FSR, 32'h0, "t4_fsr");
    show(0, 8'h8E, "t4_dig0");
    show(1, 8'h86, "t4_dig1");
    show(3, 8'h83, "t4_dig3");
    apb_write(A_FDR, 32'hFFFF);
    idle(5);
    rd_expect(A_FSR, 32'h0, "hex_ffff_ok");
    apb_write(A_FDR, 32'h1_0000);
    idle(5);
    rd_expect(A_FSR, 32'h2, "hex_ovf");
    show(0, 8'hBF, "hex_ovf_dig0");
    show(3, 8'hBF, "hex_ovf_dig3");
    apb_write(A_FCR, 32'h7);
    apb_write(A_FDR, 32'hA);
    idle(5);
    show(0, 8'h88, "hex_lzb_dig0");
    show(1, 8'hFF, "hex_lzb_dig1");

    // Restart mid-conversion: busy stays high, 9999 is never displayed
    apb_write(A_FCR, 32'h1);
    idle(30);
    apb_write(A_FDR, 32'd1234);
    idle(30);
    seen_nine = 0;
    watch_nine = 1'b1;
    apb_write(A_FDR, 32'd9999);
    idle(1);
    apb_write(A_FDR, 32'd42);
    for (int i = 0; i < 10; i++) rd_expect(A_FSR, 32'h1, $sformatf("t5_busy_%0d", i));
    idle(30);
    rd_expect(A_FSR, 32'h0, "t5_idle");
    show(0, 8'hA4, "t5_dig0");
    show(1, 8'h99, "t5_dig1");
    show(2, 8'hC0, "t5_dig2");
    show(3, 8'hC0, "t5_dig3");
    watch_nine = 1'b0;
    check("t5_never_9999", seen_nine, 32'd0);

    // Blink with 8-cycle half period, dp mask on digit 1
    apb_write(A_FPR, 32'h2);
    apb_write(A_FCR, 32'h9);
    found = 1'b0; prev_lit = 1'b0; c = 0;
    while (!found && c < 100) begin
      @(negedge clk);
      c++;
      if (prev_lit && fnd_comm == 4'hF) found = 1'b1;
      prev_lit = (fnd_comm != 4'hF);
    end
    check("blink_edge_seen", {31'd0, found}, 32'd1);
    run = 1; done = 1'b0;
    while (!done && run < 40) begin
      @(negedge clk);
      if (fnd_comm == 4'hF) run++; else done = 1'b1;
    end
    check("blink_off_len", run, 32'd8);
    run = 1; done = 1'b0;
    while (!done && run < 40) begin
      @(negedge clk);
      if (fnd_comm != 4'hF) run++; else done = 1'b1;
    end
    check("blink_on_len", run, 32'd8);
    show(1, 8'h19, "t6_dig1_dp");
    show(0, 8'hA4, "t6_dig0_nodp");

    // Reset in the middle of a conversion
    apb_write(A_FDR, 32'd9999);
    idle(3);
    PRESET = 1'b1;
    idle(1);
    PRESET = 1'b0;
    check("rst2_comm", {28'd0, fnd_comm}, 32'hF);
    check("rst2_font", {24'd0, fnd_font}, 32'hFF);
    rd_expect(A_FSR, 32'h0, "rst2_fsr");
    rd_expect(A_FDR, 32'h0, "rst2_fdr");
    apb_write(A_FCR, 32'h1);
    show(0, 8'hC0, "rst2_dig0");
    show(1, 8'hC0, "rst2_dig1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_fnd_scan_ctrl.md
# apb_fnd_scan_ctrl

APB-slave seven-segment display controller, the parametrised successor to the fixed 4-digit FND counter peripheral. It drives NUM_DIGITS multiplexed digits with decimal or hex display modes and converts binary to BCD iteratively instead of with combinational divide/modulo. It adds leading-zero blanking, blink, a per-digit decimal-point mask and a readable status register. It sits on the APB bus beside the other peripherals, with fnd_comm/fnd_font exported to board pins.

## Interface
- NUM_DIGITS, 4: digits scanned, range 1..8.
- DATA_W, 14: FDR value width, range 4..32.
- TICK_DIV, 100_000: PCLK cycles per digit-scan tick, ≥2.
- BLINK_DIV, 250: scan ticks per blink half-period, ≥1.
- PCLK  in  1  system clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- PADDR  in  4  byte address; PADDR[3:2] selects the register.
- PWDATA  in  32  write data.
- PWRITE, PENABLE, PSEL  in  1 each  APB control.
- PRDATA  out  32  read data, registered.
- PREADY  out  1  transfer complete, registered.
- fnd_comm  out  NUM_DIGITS  digit enables, active-low one-hot.
- fnd_font  out  8  {dp, g..a}, active-low.

## Operation
- Registers:
  - 0x0 FCR, RW: bit0 enable, bit1 hex mode, bit2 leading-zero blank, bit3 blink.
  - 0x4 FDR, RW: value [DATA_W-1:0].
  - 0x8 FPR, RW: dp mask [NUM_DIGITS-1:0], 1 = dp lit.
  - 0xC FSR, RO: bit0 busy, bit1 overflow.
- Register writes store only the implemented bits. Unimplemented bits read 0. Writes to FSR are ignored.
- APB access:
  - On the edge where PSEL & PENABLE & !PREADY, commit the write or capture PRDATA, and set PREADY=1.
  - On the next edge, PREADY=0.
  - This gives exactly one wait state per transfer.
- Conversion FSM, states IDLE, SHIFT, LOAD:
  - A write to FDR, or a write to FCR that changes bit1, moves the FSM to SHIFT and sets busy.
  - Decimal SHIFT runs a double-dabble for DATA_W cycles over NUM_DIGITS BCD nibbles.
  - Hex mode skips SHIFT: IDLE goes directly to LOAD.
  - LOAD copies the result into the display buffer, clears busy and returns to IDLE.
  - A new trigger during SHIFT or LOAD restarts the conversion from SHIFT with the new value. The display buffer holds its old contents until a LOAD completes.
- Overflow:
  - Overflow = (value > 10^NUM_DIGITS − 1) in decimal mode, or nonzero bits above 4·NUM_DIGITS in hex mode.
  - Overflow is latched at LOAD.
  - While overflow=1, every digit shows "-" (g only, font 0xBF), dp included per the mask.
- Scan:
  - The divider counts 0..TICK_DIV−1 and pulses a tick at the terminal count.
  - On each tick the digit index advances and wraps from NUM_DIGITS−1 to 0.
  - Blink phase toggles every BLINK_DIV ticks.
- Output:
  - fnd_comm = ~(1<<idx) when enable=1 and (blink=0 or blink phase on). Otherwise all 1s.
  - fnd_font[6:0] = segment code of the buffer nibble. Codes: 0–9, A–F standard, 0xF in decimal unused.
  - fnd_font[7] = ~FPR[idx].
  - Leading-zero blank: digits above the most-significant nonzero digit emit 0x7F segments with dp per the mask. Digit 0 is never blanked.

## Timing
- Reset values:
  - PRDATA=0, PREADY=0.
  - FCR/FDR/FPR=0, FSR=0.
  - FSM in IDLE, buffer all zero.
  - Divider, index and blink phase = 0.
  - fnd_comm all 1s, fnd_font=0xFF.
- Reset mid-conversion aborts the conversion. The buffer is cleared.
- Display latency from the FDR write edge to the buffer update:
  - Decimal: DATA_W+2 cycles.
  - Hex: 2 cycles.
- fnd_comm and fnd_font are registered, one cycle after the index or buffer changes.
- Scan and APB run independently. A tick coincident with LOAD shows the new buffer at the new index.
- A read of FSR in the same cycle as a trigger returns busy=0. The following read returns 1.

## Structure
- Package fnd_pkg holds:
  - register offset constants;
  - FCR bit-position constants;
  - the conversion-state enum;
  - the seg7 lookup function;
  - the dash/blank font constants.
- Sub-module fnd_bin2bcd: the iterative double-dabble engine, parametrised by DATA_W and NUM_DIGITS, with start/busy/done handshake.
- APB register file, scan divider and output mux live in the top module.

## Test plan
- Reset, then read FCR, FDR, FPR and FSR → all 0. fnd_comm=all 1s, fnd_font=0xFF.
- TICK_DIV=4, write FCR=0x1, FDR=1234 → busy for DATA_W+1 cycles, then digits scan 4,3,2,1 with fnd_comm 1110,1101,1011,0111 every 4 cycles.
- FCR=0x5, FDR=7 → only digit 0 shows 0xF8. Digits 1–3 show 0xFF.
- FCR=0x3, FDR=0xBEEF → hex digits F,E,E,B. Then FDR=0x1_0000 → overflow=1 and all digits 0xBF.
- Write FDR=9999, then FDR=42 three cycles later → the first conversion aborts, the buffer goes directly from old contents to 0042, and busy stays continuously high.
- Blink=1, BLINK_DIV=2, FPR=0x2 → fnd_comm is all 1s for alternate 2-tick windows. Digit 1 shows fnd_font[7]=0.
